// File: rtl/data_mem_pkg.sv
// Shared constants and enums for the data memory arbiter.
package data_mem_pkg;

  localparam int DATA_W    = 16;
  localparam int ADDR_W    = 16;
  localparam int MEM_DEPTH = 256;

  typedef enum logic [0:0] {
    PRI0   = 1'b0,
    FORCE1 = 1'b1
  } arb_state_e;

  typedef enum logic [0:0] {
    PORT0 = 1'b0,
    PORT1 = 1'b1
  } port_e;

endpackage

// File: rtl/mem_arb_starve_ctr.sv
// Port 1 starvation counter and the two-state arbitration FSM.
//   state  | meaning
//   PRI0   | port 0 has priority
//   FORCE1 | port 1 has waited MAX_WAIT cycles and wins next
module mem_arb_starve_ctr
  import data_mem_pkg::*;
#(
  parameter int MAX_WAIT = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic m1_req_i,
  input  logic m1_gnt_i,
  output logic force1_o
);

  localparam logic [3:0] MAX_WAIT_C = 4'(MAX_WAIT);

  arb_state_e state_q;
  logic [3:0] wait_cnt_q;
  logic [3:0] wait_cnt_d;

  always_comb begin
    wait_cnt_d = wait_cnt_q;
    if (!m1_req_i || m1_gnt_i) begin
      wait_cnt_d = 4'd0;
    end else if (wait_cnt_q != 4'hF) begin
      wait_cnt_d = wait_cnt_q + 4'd1;
    end
  end

  // Switching on the incremented count lets port 1 win on cycle MAX_WAIT+1.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q    <= PRI0;
      wait_cnt_q <= 4'd0;
    end else begin
      wait_cnt_q <= wait_cnt_d;
      if (state_q == PRI0) begin
        if (wait_cnt_d >= MAX_WAIT_C) state_q <= FORCE1;
      end else begin
        if (m1_gnt_i || !m1_req_i) state_q <= PRI0;
      end
    end
  end

  assign force1_o = (state_q == FORCE1);

endmodule

// File: rtl/data_mem_arbiter.sv
// Two-port arbiter in front of a single-port combinational-read data memory,
// with registered read return and out-of-range error pulses.
module data_mem_arbiter #(
  parameter int DATA_W    = data_mem_pkg::DATA_W,
  parameter int ADDR_W    = data_mem_pkg::ADDR_W,
  parameter int MEM_DEPTH = data_mem_pkg::MEM_DEPTH,
  parameter int MAX_WAIT  = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              m0_req,
  input  logic              m0_we,
  input  logic [ADDR_W-1:0] m0_addr,
  input  logic [DATA_W-1:0] m0_wdata,
  output logic              m0_gnt,
  output logic              m0_rvalid,
  output logic [DATA_W-1:0] m0_rdata,
  output logic              m0_err,
  input  logic              m1_req,
  input  logic              m1_we,
  input  logic [ADDR_W-1:0] m1_addr,
  input  logic [DATA_W-1:0] m1_wdata,
  output logic              m1_gnt,
  output logic              m1_rvalid,
  output logic [DATA_W-1:0] m1_rdata,
  output logic              m1_err,
  output logic              mem_we,
  output logic [ADDR_W-1:0] mem_addr,
  output logic [DATA_W-1:0] mem_wdata,
  input  logic [DATA_W-1:0] mem_rdata
);

  localparam logic [ADDR_W:0] DEPTH_C = (ADDR_W+1)'(MEM_DEPTH);

  logic               force1;
  logic               any_gnt;
  logic               win_we;
  logic [ADDR_W-1:0]  win_addr;
  logic [DATA_W-1:0]  win_wdata;
  logic               in_range;
  data_mem_pkg::port_e winner;

  logic              m0_rvalid_q, m1_rvalid_q;
  logic              m0_err_q, m1_err_q;
  logic [DATA_W-1:0] m0_rdata_q, m1_rdata_q;

  mem_arb_starve_ctr #(.MAX_WAIT(MAX_WAIT)) u_starve (
    .clk      (clk),
    .rst_n    (rst_n),
    .m1_req_i (m1_req),
    .m1_gnt_i (m1_gnt),
    .force1_o (force1)
  );

  // Grants are masked during reset so nothing reaches the memory.
  assign m0_gnt  = rst_n && m0_req && (!force1 || !m1_req);
  assign m1_gnt  = rst_n && m1_req && (force1 || !m0_req);
  assign any_gnt = m0_gnt || m1_gnt;
  assign winner  = m1_gnt ? data_mem_pkg::PORT1 : data_mem_pkg::PORT0;

  always_comb begin
    win_we    = 1'b0;
    win_addr  = '0;
    win_wdata = '0;
    if (m0_gnt) begin
      win_we    = m0_we;
      win_addr  = m0_addr;
      win_wdata = m0_wdata;
    end else if (m1_gnt) begin
      win_we    = m1_we;
      win_addr  = m1_addr;
      win_wdata = m1_wdata;
    end
  end

  assign in_range  = ({1'b0, win_addr} < DEPTH_C);
  assign mem_we    = win_we && in_range;
  assign mem_addr  = win_addr;
  assign mem_wdata = win_wdata;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m0_rvalid_q <= 1'b0;
      m1_rvalid_q <= 1'b0;
      m0_err_q    <= 1'b0;
      m1_err_q    <= 1'b0;
      m0_rdata_q  <= '0;
      m1_rdata_q  <= '0;
    end else begin
      m0_rvalid_q <= any_gnt && !win_we && (winner == data_mem_pkg::PORT0);
      m1_rvalid_q <= any_gnt && !win_we && (winner == data_mem_pkg::PORT1);
      m0_err_q    <= any_gnt && !in_range && (winner == data_mem_pkg::PORT0);
      m1_err_q    <= any_gnt && !in_range && (winner == data_mem_pkg::PORT1);
      if (any_gnt && !win_we) begin
        if (winner == data_mem_pkg::PORT0) m0_rdata_q <= in_range ? mem_rdata : '0;
        else                               m1_rdata_q <= in_range ? mem_rdata : '0;
      end
    end
  end

  assign m0_rvalid = m0_rvalid_q;
  assign m1_rvalid = m1_rvalid_q;
  assign m0_err    = m0_err_q;
  assign m1_err    = m1_err_q;
  assign m0_rdata  = m0_rdata_q;
  assign m1_rdata  = m1_rdata_q;

endmodule
